volume_ctrl_multi: RTL

Multi-channel volume controller, parametrised successor of the single-channel saturating volume counter. Holds one stored level and one mute flag per channel, applies configurable-size saturating steps from the UP/DOWN key interface, and adds hold-to-repeat with programmable delay and rate. Sits between the keypad/debounce logic and the audio gain stage; its per-channel outputs drive the gain multipliers directly.

---
 rtl/volume_ctrl_multi_if.sv | 28 ++
 rtl/volume_ctrl_multi.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/volume_ctrl_multi_if.sv
// rtl/volume_ctrl_multi_if.sv - key/mute request and per-channel volume bundle
interface volume_ctrl_multi_if #(
    parameter int COUNT_SIZE = 8,
    parameter int CHANNELS   = 2,
    parameter int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                           VOLUP;
    logic                           VOLDOWN;
    logic                           VOLVALID;
    logic [CHW-1:0]                 CH_SEL;
    logic                           ALL;
    logic                           MUTE_TOGGLE;
    logic [CHANNELS*COUNT_SIZE-1:0] volume;
    logic [CHANNELS-1:0]            muted;
    logic                           limit_hit;

    // Keypad side drives requests and observes the gain settings
    modport master (
        output VOLUP, VOLDOWN, VOLVALID, CH_SEL, ALL, MUTE_TOGGLE,
        input  volume, muted, limit_hit
    );

    // Controller side
    modport slave (
        input  VOLUP, VOLDOWN, VOLVALID, CH_SEL, ALL, MUTE_TOGGLE,
        output volume, muted, limit_hit
    );
endinterface

// File: rtl/volume_ctrl_multi.sv
// rtl/volume_ctrl_multi.sv - multi-channel saturating volume control with hold-to-repeat
module volume_ctrl_multi #(
    parameter int COUNT_SIZE   = 8,
    parameter int CHANNELS     = 2,
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 5_000_000,
    parameter int REPEAT_RATE  = 1_000_000,
    parameter int RESET_VOL    = 0
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    volume_ctrl_multi_if.slave   bus
);
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int KW      = CHW + 2;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [COUNT_SIZE:0]   STEP_W  = (COUNT_SIZE+1)'(STEP);
    localparam logic [COUNT_SIZE-1:0] LVL_MAX = '1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [KW-1:0]         key_q, key_d;
    logic [COUNT_SIZE-1:0] lvl_q [CHANNELS];
    logic [COUNT_SIZE-1:0] lvl_d [CHANNELS];
    logic [CHANNELS-1:0]   muted_q, muted_d;
    logic                  limit_hit_q, limit_hit_d;

    logic                  req;
    logic [KW-1:0]         key;
    logic                  step;
    logic [CHANNELS-1:0]   tgt;
    logic                  any_changed;
    logic [COUNT_SIZE:0]   sum;
    logic [COUNT_SIZE-1:0] nxt;

    // A request needs exactly one of UP/DOWN; the key identifies one "press"
    assign req = bus.VOLVALID & (bus.VOLUP ^ bus.VOLDOWN);
    assign key = {bus.VOLUP, bus.ALL, bus.CH_SEL};

    // Repeat FSM: step on a new press, after the delay, then at the repeat rate
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    step    = 1'b1;
                    cnt_d   = CNTW'(1);
                    key_d   = key;
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (key != key_q) begin
                    step    = 1'b1;
                    cnt_d   = CNTW'(1);
                    key_d   = key;
                    state_d = DELAY;
                end else if (cnt_q == ((state_q == DELAY) ? CNTW'(REPEAT_DELAY)
                                                         : CNTW'(REPEAT_RATE))) begin
                    step    = 1'b1;
                    cnt_d   = CNTW'(1);
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-channel level/mute update; a step overrides a same-cycle mute toggle
    always_comb begin
        lvl_d       = lvl_q;
        muted_d     = muted_q;
        tgt         = '0;
        any_changed = 1'b0;
        sum         = '0;
        nxt         = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            tgt[k] = bus.ALL | (int'(bus.CH_SEL) == k);
            if (step && tgt[k]) begin
                if (bus.VOLUP) begin
                    sum = {1'b0, lvl_q[k]} + STEP_W;
                    nxt = sum[COUNT_SIZE] ? LVL_MAX : sum[COUNT_SIZE-1:0];
                end else begin
                    sum = {1'b0, lvl_q[k]};
                    nxt = (sum < STEP_W) ? '0 : lvl_q[k] - STEP_W[COUNT_SIZE-1:0];
                end
                lvl_d[k]   = nxt;
                muted_d[k] = 1'b0;
                if (nxt != lvl_q[k]) begin
                    any_changed = 1'b1;
                end
            end else if (bus.MUTE_TOGGLE && tgt[k]) begin
                muted_d[k] = ~muted_q[k];
            end
        end
        limit_hit_d = step & (|tgt) & ~any_changed;
    end

    // State, counter, key latch and channel registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            muted_q     <= '0;
            limit_hit_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                lvl_q[k] <= COUNT_SIZE'(RESET_VOL);
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            muted_q     <= muted_d;
            limit_hit_q <= limit_hit_d;
            lvl_q       <= lvl_d;
        end
    end

    // Effective volume is forced to zero while muted; the stored level is kept
    always_comb begin
        bus.volume = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.volume[k*COUNT_SIZE +: COUNT_SIZE] = muted_q[k] ? '0 : lvl_q[k];
        end
    end

    assign bus.muted     = muted_q;
    assign bus.limit_hit = limit_hit_q;
endmodule
